quad_gray_reader: RTL and testbench

Reads a 2-bit Gray-coded (quadrature) input from a rotary encoder or two switches. It is the receive-side counterpart to the board's Gray counter/LED display path.
- Synchronises and glitch-filters both input lines.
- Decodes each legal Gray step into +1/-1.
- Keeps a wrapping binary position and also exports that position in Gray code, so the existing LED and 7-segment path can display it.
- Flags illegal double-bit transitions.

---
 rtl/quad_gray_reader.sv | 163 ++++++++++++++++
 tb/tb_quad_gray_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/quad_gray_reader.sv
// rtl/quad_gray_reader.sv - quadrature Gray input reader: sync, glitch filter, step decode, position
// Tracks a wrapping binary/Gray position from a 2-bit encoder and flags illegal double-bit moves.
module quad_gray_reader #(
  parameter int WIDTH  = 8,
  parameter int FILTER = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr,
  output logic [WIDTH-1:0] position,
  output logic [WIDTH-1:0] position_gray,
  output logic             step_pulse,
  output logic             dir,
  output logic             err_pulse,
  output logic             err_sticky
);

  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int RW = $clog2(FILTER + 1);

  typedef enum logic {ST_INIT, ST_TRACK} state_t;

  state_t           state_q;
  logic [1:0]       s1_q, s2_q;
  logic [1:0]       warm_q;
  logic [1:0]       filt_q, filt_d;
  logic [1:0]       last_q;
  logic [1:0]       prev_q;
  logic [CW-1:0]    cnt_q [2];
  logic [CW-1:0]    cnt_d [2];
  logic [RW-1:0]    run_q, run_d;
  logic [WIDTH-1:0] pos_q, pos_d, gray_q;
  logic             step_q, dir_q, err_q, sticky_q;
  logic             primed, init_load;
  logic             moved, is_up, is_dn, is_bad;

  function automatic logic [1:0] gray_next(input logic [1:0] g);
    case (g)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // The two reset-zero samples still in the synchroniser must not count toward the INIT rest level.
  always_comb begin
    primed = warm_q[1];
    run_d  = '0;
    if (primed) begin
      if (s2_q != last_q)
        run_d = RW'(1);
      else if (run_q != RW'(FILTER))
        run_d = run_q + 1'b1;
      else
        run_d = run_q;
    end
    init_load = (state_q == ST_INIT) && (run_d == RW'(FILTER));
  end

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CW'(FILTER - 1))
          filt_d[i] = s2_q[i];
        else
          cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    if (init_load)
      filt_d = s2_q;
  end

  always_comb begin
    moved  = (filt_q != prev_q);
    is_up  = moved && (filt_q == gray_next(prev_q));
    is_dn  = moved && (prev_q == gray_next(filt_q));
    is_bad = moved && !is_up && !is_dn;
    pos_d  = pos_q;
    if (clr)
      pos_d = '0;
    else if (state_q == ST_TRACK) begin
      if (is_up)
        pos_d = pos_q + 1'b1;
      else if (is_dn)
        pos_d = pos_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      warm_q   <= '0;
      filt_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      last_q   <= '0;
      run_q    <= '0;
    end else begin
      s1_q     <= {enc_a, enc_b};
      s2_q     <= s1_q;
      warm_q   <= {warm_q[0], 1'b1};
      filt_q   <= filt_d;
      cnt_q[0] <= init_load ? '0 : cnt_d[0];
      cnt_q[1] <= init_load ? '0 : cnt_d[1];
      last_q   <= s2_q;
      run_q    <= run_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_INIT;
      prev_q   <= '0;
      pos_q    <= '0;
      gray_q   <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      step_q <= 1'b0;
      err_q  <= 1'b0;
      pos_q  <= pos_d;
      gray_q <= pos_d ^ (pos_d >> 1);
      if (clr)
        sticky_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (init_load) begin
            prev_q  <= s2_q;
            state_q <= ST_TRACK;
          end
        end
        default: begin
          prev_q <= filt_q;
          if (is_up || is_dn) begin
            step_q <= 1'b1;
            dir_q  <= is_up;
          end
          if (is_bad) begin
            err_q <= 1'b1;
            if (!clr)
              sticky_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign position      = pos_q;
  assign position_gray = gray_q;
  assign step_pulse    = step_q;
  assign dir           = dir_q;
  assign err_pulse     = err_q;
  assign err_sticky    = sticky_q;

endmodule

// File: tb/tb_quad_gray_reader.sv
// tb/tb_quad_gray_reader.sv - directed self-checking bench for quad_gray_reader
// A FILTER=4 instance carries most checks; a FILTER=1 instance shares inputs for the bounce case.
module tb_quad_gray_reader;

  logic       clk = 1'b0;
  logic       rst, enc_a, enc_b, clr;
  logic [7:0] pos0, gray0, pos1, gray1;
  logic       step0, dir0, err0, stk0;
  logic       step1, dir1, err1, stk1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_step0  = 0;
  int n_err0   = 0;
  int n_step1  = 0;
  int n_err1   = 0;
  int s_step0, s_err0, s_step1, s_err1;

  quad_gray_reader #(.WIDTH(8), .FILTER(4)) dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
    .position(pos0), .position_gray(gray0), .step_pulse(step0),
    .dir(dir0), .err_pulse(err0), .err_sticky(stk0)
  );

  quad_gray_reader #(.WIDTH(8), .FILTER(1)) dut_f1 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
    .position(pos1), .position_gray(gray1), .step_pulse(step1),
    .dir(dir1), .err_pulse(err1), .err_sticky(stk1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step0) n_step0++;
    if (err0)  n_err0++;
    if (step1) n_step1++;
    if (err1)  n_err1++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_step0 = n_step0;
    s_err0  = n_err0;
    s_step1 = n_step1;
    s_err1  = n_err1;
  endtask

  // Drives a new level; edge k captures it, outputs must move exactly at edge k+6.
  task automatic do_step(input string tag, input logic [1:0] ab, input logic [7:0] pos_before,
                         input logic [7:0] exp_pos, input logic [7:0] exp_gray, input logic exp_dir,
                         input logic exp_step, input logic exp_err, input logic with_clr);
    {enc_a, enc_b} = ab;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check({tag, "_pre_pos"}, pos0, pos_before);
    check({tag, "_pre_step"}, step0, 1'b0);
    check({tag, "_pre_err"}, err0, 1'b0);
    clr = with_clr;
    tick();
    clr = 1'b0;
    check({tag, "_pos"}, pos0, exp_pos);
    check({tag, "_gray"}, gray0, exp_gray);
    check({tag, "_dir"}, dir0, exp_dir);
    check({tag, "_step"}, step0, exp_step);
    check({tag, "_err"}, err0, exp_err);
    tick();
    check({tag, "_step_end"}, step0, 1'b0);
    check({tag, "_err_end"}, err0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b0;
    clr = 1'b0;
    {enc_a, enc_b} = 2'b11;
    repeat (3) tick();
    check("rst_pos", pos0, 8'h00);
    check("rst_gray", gray0, 8'h00);
    check("rst_step", step0, 1'b0);
    check("rst_dir", dir0, 1'b0);
    check("rst_err", err0, 1'b0);
    check("rst_sticky", stk0, 1'b0);

    rst = 1'b1;
    snap();
    repeat (20) tick();
    check("init11_steps", n_step0 - s_step0, 0);
    check("init11_errs", n_err0 - s_err0, 0);
    check("init11_pos", pos0, 8'h00);

    do_step("exit_10", 2'b10, 8'd0, 8'd1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    do_step("exit_00", 2'b00, 8'd1, 8'd2, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_pos", pos0, 8'h00);
    check("clr_gray", gray0, 8'h00);

    do_step("up_01", 2'b01, 8'd0, 8'd1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    do_step("up_11", 2'b11, 8'd1, 8'd2, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    do_step("up_10", 2'b10, 8'd2, 8'd3, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    do_step("up_00", 2'b00, 8'd3, 8'd4, 8'h06, 1'b1, 1'b1, 1'b0, 1'b0);
    do_step("dn_10", 2'b10, 8'd4, 8'd3, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    do_step("dn_11", 2'b11, 8'd3, 8'd2, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    do_step("dn_01", 2'b01, 8'd2, 8'd1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    do_step("dn_00", 2'b00, 8'd1, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    do_step("wrap_10", 2'b10, 8'd0, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    do_step("wrap_00", 2'b00, 8'hFF, 8'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

    snap();
    for (int r = 0; r < 5; r++) begin
      enc_a = 1'b1;
      repeat (3) tick();
      enc_a = 1'b0;
      repeat (3) tick();
    end
    repeat (10) tick();
    check("bounce_f4_steps", n_step0 - s_step0, 0);
    check("bounce_f4_errs", n_err0 - s_err0, 0);
    check("bounce_f4_pos", pos0, 8'h00);
    check("bounce_f1_steps", n_step1 - s_step1, 10);
    check("bounce_f1_errs", n_err1 - s_err1, 0);
    check("bounce_f1_pos", pos1, 8'h00);
    check("bounce_f1_gray", gray1, 8'h00);
    check("bounce_f1_dir", dir1, 1'b1);
    check("bounce_f1_sticky", stk1, 1'b0);

    do_step("err_11", 2'b11, 8'd0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    check("err_sticky_set", stk0, 1'b1);
    do_step("after_err_10", 2'b10, 8'd0, 8'd1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    check("err_sticky_hold", stk0, 1'b1);
    do_step("to5_00", 2'b00, 8'd1, 8'd2, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    do_step("to5_01", 2'b01, 8'd2, 8'd3, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    do_step("to5_11", 2'b11, 8'd3, 8'd4, 8'h06, 1'b1, 1'b1, 1'b0, 1'b0);
    do_step("to5_10", 2'b10, 8'd4, 8'd5, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    do_step("clr_step", 2'b00, 8'd5, 8'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_sticky", stk0, 1'b0);
    do_step("post_clr_01", 2'b01, 8'd0, 8'd1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);

    {enc_a, enc_b} = 2'b11;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_pos", pos0, 8'h00);
    check("arst_gray", gray0, 8'h00);
    check("arst_dir", dir0, 1'b0);
    check("arst_step", step0, 1'b0);
    check("arst_err", err0, 1'b0);
    check("arst_sticky", stk0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    snap();
    repeat (20) tick();
    check("rerun_steps", n_step0 - s_step0, 0);
    check("rerun_errs", n_err0 - s_err0, 0);
    check("rerun_pos", pos0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
